// File: rtl/m1reset_pkg.sv
// Shared constants and types for the reset-request arbiter.
// Cause-bit positions and the arbiter state encoding live here.
package m1reset_pkg;

    localparam int unsigned CAUSE_BTN = 0;
    localparam int unsigned CAUSE_SW  = 1;
    localparam int unsigned CAUSE_WDT = 2;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StFire    = 2'd1,
        StHoldoff = 2'd2
    } state_e;

    function automatic logic [2:0] cause_vec(input logic btn, input logic sw, input logic wdt);
        logic [2:0] v;
        v            = '0;
        v[CAUSE_BTN] = btn;
        v[CAUSE_SW]  = sw;
        v[CAUSE_WDT] = wdt;
        return v;
    endfunction

endpackage

// File: rtl/m1reset_trigger_if.sv
// Control/status bundle between a system controller and the reset-request arbiter.
// The controller side is master; the arbiter side is slave.
interface m1reset_trigger_if #(
    parameter int unsigned WDT_W = 24
) ();

    logic             sw_rst_req;
    logic             wdt_en;
    logic             wdt_kick;
    logic [WDT_W-1:0] wdt_reload;
    logic             cause_clr;
    logic             trigger_reset;
    logic [2:0]       rst_cause;
    logic [WDT_W-1:0] wdt_count;

    modport master (
        output sw_rst_req, wdt_en, wdt_kick, wdt_reload, cause_clr,
        input  trigger_reset, rst_cause, wdt_count
    );

    modport slave (
        input  sw_rst_req, wdt_en, wdt_kick, wdt_reload, cause_clr,
        output trigger_reset, rst_cause, wdt_count
    );

endinterface

// File: rtl/m1reset_debounce.sv
// Pushbutton synchronizer and debouncer; emits a one-cycle btn_event on a committed press.
// A level must differ from the stable value for 2**DEBOUNCE_W cycles before it is committed.
module m1reset_debounce #(
    parameter int unsigned DEBOUNCE_W = 16
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic btn_n,
    output logic btn_event
);

    logic [1:0]            sync_q;
    logic                  stable_q, stable_d;
    logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;
    logic                  event_q, event_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == '1) begin
                stable_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Only a press (1->0) is an event; release is silent.
        event_d = stable_q & ~stable_d;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q   <= 2'b11;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            event_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], btn_n};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            event_q  <= event_d;
        end
    end

    assign btn_event = event_q;

endmodule

// File: rtl/m1reset_trigger.sv
// Reset-request arbiter: merges button, software and watchdog requests into one trigger pulse
// with holdoff, and keeps a sticky cause register cleared only by power-on reset or cause_clr.
module m1reset_trigger
    import m1reset_pkg::*;
#(
    parameter int unsigned DEBOUNCE_W = 16,
    parameter int unsigned WDT_W      = 24,
    parameter int unsigned HOLDOFF_W  = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             btn_n,
    m1reset_trigger_if.slave bus
);

    logic                 btn_event;
    logic [2:0]           events;
    state_e               state_q, state_d;
    logic [HOLDOFF_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [WDT_W-1:0]     wdt_cnt_q, wdt_cnt_d;
    logic                 wdt_event_q, wdt_event_d;
    logic                 trig_q, trig_d;
    logic [2:0]           cause_q, cause_d;

    m1reset_debounce #(
        .DEBOUNCE_W(DEBOUNCE_W)
    ) u_debounce (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .btn_n    (btn_n),
        .btn_event(btn_event)
    );

    // Expiry is registered, so the arbiter sees it the cycle after the count reaches zero.
    always_comb begin
        wdt_event_d = 1'b0;
        if (!bus.wdt_en || state_q != StIdle || bus.wdt_kick) begin
            wdt_cnt_d = bus.wdt_reload;
        end else if (wdt_cnt_q == '0) begin
            wdt_cnt_d   = bus.wdt_reload;
            wdt_event_d = 1'b1;
        end else begin
            wdt_cnt_d = wdt_cnt_q - 1'b1;
        end
    end

    assign events = cause_vec(btn_event, bus.sw_rst_req, wdt_event_q);

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        trig_d     = 1'b0;
        cause_d    = bus.cause_clr ? 3'b000 : cause_q;
        unique case (state_q)
            StIdle: begin
                if (|events) begin
                    state_d = StFire;
                    trig_d  = 1'b1;
                    cause_d = cause_d | events;
                end
            end
            StFire: begin
                state_d    = StHoldoff;
                hold_cnt_d = '0;
            end
            StHoldoff: begin
                if (hold_cnt_q == '1) begin
                    state_d = StIdle;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= StIdle;
            hold_cnt_q  <= '0;
            wdt_cnt_q   <= bus.wdt_reload;
            wdt_event_q <= 1'b0;
            trig_q      <= 1'b0;
            cause_q     <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            wdt_cnt_q   <= wdt_cnt_d;
            wdt_event_q <= wdt_event_d;
            trig_q      <= trig_d;
            cause_q     <= cause_d;
        end
    end

    assign bus.trigger_reset = trig_q;
    assign bus.rst_cause     = cause_q;
    assign bus.wdt_count     = wdt_cnt_q;

endmodule

// File: tb/tb_m1reset_trigger.sv
// Self-checking bench for m1reset_trigger: vector table plus hand sequences, scoreboard of
// expected trigger pulses (cycle, cause) popped when the DUT pulses.
module tb_m1reset_trigger;
    import m1reset_pkg::*;

    localparam int unsigned DEBOUNCE_W = 4;
    localparam int unsigned WDT_W      = 8;
    localparam int unsigned HOLDOFF_W  = 3;

    localparam int K_SW     = 0;
    localparam int K_WDT    = 1;
    localparam int K_KICK   = 2;
    localparam int K_SIM    = 3;
    localparam int K_BTN    = 4;
    localparam int K_GLITCH = 5;
    localparam int K_CLR    = 6;
    localparam int NVEC     = 13;

    typedef struct {
        int         kind;
        int         arg;
        bit         clr;
        bit         exp_pulse;
        int         exp_lat;
        logic [2:0] exp_cause;
    } vec_t;

    typedef struct {
        int         cyc;
        logic [2:0] cause;
    } sb_t;

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    logic btn_n;

    m1reset_trigger_if #(.WDT_W(WDT_W)) bus ();

    m1reset_trigger #(
        .DEBOUNCE_W(DEBOUNCE_W),
        .WDT_W     (WDT_W),
        .HOLDOFF_W (HOLDOFF_W)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .btn_n    (btn_n),
        .bus      (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    bit         pulse_seen;
    logic [2:0] model_cause;
    sb_t        sb_q[$];
    vec_t       vecs[NVEC];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d cycle=%0d", name, got, exp, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    task automatic push_exp(input int c, input logic [2:0] cause);
        sb_t e;
        e.cyc   = c;
        e.cause = cause;
        sb_q.push_back(e);
    endtask

    task automatic sample();
        sb_t e;
        @(negedge sys_clk);
        if (bus.trigger_reset !== 1'b0) begin
            pulse_seen = 1'b1;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse got=1 exp=0 cycle=%0d", cyc);
            end else begin
                e = sb_q.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_cause", {29'd0, bus.rst_cause}, {29'd0, e.cause});
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            bus.sw_rst_req = 1'b0;
            bus.wdt_kick   = 1'b0;
            bus.wdt_en     = 1'b0;
            bus.cause_clr  = 1'b0;
            btn_n          = 1'b1;
            sample();
        end
    endtask

    task automatic run_vec(input vec_t v);
        int t0;
        if (v.kind == K_WDT || v.kind == K_KICK || v.kind == K_SIM) bus.wdt_reload = 8'(v.arg);
        pulse_seen = 1'b0;
        next_cycle();
        t0            = cyc;
        bus.cause_clr = v.clr;
        case (v.kind)
            K_SW:                bus.sw_rst_req = 1'b1;
            K_WDT, K_KICK, K_SIM: bus.wdt_en    = 1'b1;
            K_BTN, K_GLITCH:     btn_n          = 1'b0;
            default: ;
        endcase
        if (v.clr) model_cause = 3'b000;
        if (v.exp_pulse) begin
            model_cause = model_cause | v.exp_cause;
            push_exp(t0 + v.exp_lat, model_cause);
        end
        sample();
        for (int n = 1; n <= 40; n++) begin
            next_cycle();
            bus.cause_clr  = 1'b0;
            bus.sw_rst_req = (v.kind == K_SIM && n == v.arg + 1);
            bus.wdt_kick   = (v.kind == K_KICK && n % 4 == 0);
            if (v.kind == K_GLITCH && n == v.arg) btn_n = 1'b1;
            if (pulse_seen) bus.wdt_en = 1'b0;
            sample();
            if (v.kind == K_WDT && v.arg > 0 && n == 1)
                check("wdt_count_dec", {24'd0, bus.wdt_count}, v.arg - 1);
        end
        idle(24);
        check("missed_pulse", sb_q.size(), 0);
        check("cause_end", {29'd0, bus.rst_cause}, {29'd0, model_cause});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{K_BTN,    0,  1'b1, 1'b1, 19, 3'b001};
        vecs[1]  = '{K_GLITCH, 10, 1'b0, 1'b0, 0,  3'b000};
        vecs[2]  = '{K_GLITCH, 15, 1'b1, 1'b0, 0,  3'b000};
        vecs[3]  = '{K_GLITCH, 16, 1'b0, 1'b1, 19, 3'b001};
        vecs[4]  = '{K_WDT,    5,  1'b1, 1'b1, 7,  3'b100};
        vecs[5]  = '{K_KICK,   5,  1'b0, 1'b0, 0,  3'b000};
        vecs[6]  = '{K_SW,     0,  1'b0, 1'b1, 1,  3'b010};
        vecs[7]  = '{K_SIM,    5,  1'b1, 1'b1, 7,  3'b110};
        vecs[8]  = '{K_CLR,    0,  1'b1, 1'b0, 0,  3'b000};
        vecs[9]  = '{K_SW,     0,  1'b1, 1'b1, 1,  3'b010};
        vecs[10] = '{K_WDT,    0,  1'b0, 1'b1, 2,  3'b100};
        vecs[11] = '{K_WDT,    12, 1'b1, 1'b1, 14, 3'b100};
        vecs[12] = '{K_BTN,    0,  1'b0, 1'b1, 19, 3'b001};

        sys_rst_n      = 1'b0;
        btn_n          = 1'b1;
        bus.sw_rst_req = 1'b0;
        bus.wdt_en     = 1'b0;
        bus.wdt_kick   = 1'b0;
        bus.wdt_reload = 8'd5;
        bus.cause_clr  = 1'b0;
        model_cause    = 3'b000;

        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_trigger", {31'd0, bus.trigger_reset}, 0);
        check("rst_cause", {29'd0, bus.rst_cause}, 0);
        check("rst_wdt_count", {24'd0, bus.wdt_count}, 5);
        #1 sys_rst_n = 1'b1;
        cyc = 0;

        // Async reset while in holdoff returns straight to idle and clears the cause.
        next_cycle();
        bus.sw_rst_req = 1'b1;
        push_exp(cyc + 1, 3'b010);
        sample();
        next_cycle();
        bus.sw_rst_req = 1'b0;
        sample();
        repeat (2) begin
            next_cycle();
            sample();
        end
        next_cycle();
        sys_rst_n = 1'b0;
        #1;
        check("midrst_trigger", {31'd0, bus.trigger_reset}, 0);
        check("midrst_cause", {29'd0, bus.rst_cause}, 0);
        check("midrst_state", {30'd0, dut.state_q}, {30'd0, StIdle});
        check("midrst_wdt_count", {24'd0, bus.wdt_count}, 5);
        #1 sys_rst_n = 1'b1;
        sample();
        next_cycle();
        bus.sw_rst_req = 1'b1;
        model_cause    = 3'b010;
        push_exp(cyc + 1, 3'b010);
        sample();
        idle(12);
        check("midrst_missed", sb_q.size(), 0);

        for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

        // Holdoff: requests at pulse+1 and pulse+8 are dropped, pulse+10 fires again.
        bus.wdt_reload = 8'd5;
        idle(1);
        next_cycle();
        begin
            int t0;
            t0            = cyc;
            bus.cause_clr = 1'b1;
            bus.wdt_en    = 1'b1;
            model_cause   = 3'b100;
            push_exp(t0 + 7, 3'b100);
            sample();
            for (int n = 1; n <= 24; n++) begin
                next_cycle();
                bus.cause_clr  = 1'b0;
                if (n >= 8) bus.wdt_en = 1'b0;
                bus.sw_rst_req = (n == 8 || n == 15 || n == 17);
                if (n == 17) push_exp(t0 + 18, 3'b110);
                sample();
                if (n == 16) check("holdoff_cause", {29'd0, bus.rst_cause}, 4);
            end
        end
        model_cause = 3'b110;
        idle(12);
        check("holdoff_missed", sb_q.size(), 0);
        check("holdoff_cause_end", {29'd0, bus.rst_cause}, {29'd0, model_cause});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
